// File: rtl/div_pkg.sv
// Shared constants and FSM state type for the sequential restoring divider.
// Holds default operand widths and the IDLE/CALC/DONE state encoding.
package div_pkg;

  localparam int DW_DEF = 8;
  localparam int VW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sub_cell.sv
// One restoring-division step: trial subtract of the divisor from the
// shifted partial remainder, restore mux, and the resulting quotient bit.
// Ports: rem_in (VW+1, shifted remainder), dvs (VW, divisor),
//        rem_out (VW+1, next remainder), q (quotient bit).
module sub_cell #(
  parameter int VW = 4
) (
  input  logic [VW:0]   rem_in,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   rem_out,
  output logic          q
);

  // One extra bit so the MSB is the borrow of the trial subtract.
  logic [VW+1:0] diff;

  assign diff    = {1'b0, rem_in} - {2'b00, dvs};
  assign q       = ~diff[VW+1];
  assign rem_out = q ? diff[VW:0] : rem_in;

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
// Ports: clk, rst_n (async low), in_valid/in_ready + dividend (DW), divisor (VW);
//        out_valid/out_ready + quotient (DW), remainder (VW), div_by_zero.
// Build option: DIVZ_FAST_EN finishes a zero-divisor op in one step and flags it.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  state_t state_q;
  state_t state_d;

  // dvd_q shifts dividend bits out the top and quotient bits in the bottom.
  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   rem_q;
  logic [CW-1:0] cnt_q;

  logic [VW:0]   rem_sh;
  logic [VW:0]   rem_nx;
  logic          q_bit;
  logic          last;

  // For a nonzero divisor rem_q stays below the divisor, so its MSB is
  // always 0 before the shift; dropping it is safe.
  logic unused_msb;
  assign unused_msb = rem_q[VW];

  assign rem_sh = {rem_q[VW-1:0], dvd_q[DW-1]};

  sub_cell #(
    .VW(VW)
  ) u_cell (
    .rem_in (rem_sh),
    .dvs    (dvs_q),
    .rem_out(rem_nx),
    .q      (q_bit)
  );

`ifdef DIVZ_FAST_EN
  logic dz_q;
  assign last = (cnt_q == CW'(DW - 1)) || dz_q;
  assign div_by_zero = (state_q == DONE) && dz_q;
`else
  assign last = (cnt_q == CW'(DW - 1));
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      dvs_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
`ifdef DIVZ_FAST_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            cnt_q <= '0;
`ifdef DIVZ_FAST_EN
            dz_q  <= (divisor == '0);
`endif
          end
        end
        CALC: begin
`ifdef DIVZ_FAST_EN
          if (dz_q) begin
            dvd_q <= '1;
            rem_q <= {1'b0, dvd_q[VW-1:0]};
          end else begin
            dvd_q <= {dvd_q[DW-2:0], q_bit};
            rem_q <= rem_nx;
            cnt_q <= cnt_q + CW'(1);
          end
`else
          dvd_q <= {dvd_q[DW-2:0], q_bit};
          rem_q <= rem_nx;
          cnt_q <= cnt_q + CW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign quotient  = out_valid ? dvd_q : '0;
  assign remainder = out_valid ? rem_q[VW-1:0] : '0;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomised and directed bench for seq_restoring_divider against an
// arithmetic reference (/ and %), covering latency, hold, and reset abort.
module tb_seq_restoring_divider;

  localparam int DW = 8;
  localparam int VW = 4;

`ifdef DIVZ_FAST_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(
    .DW(DW),
    .VW(VW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_op(input int dd, input int dv, input int hold);
    int eq;
    int er;
    int edz;
    int elat;
    int lat;
    if (dv == 0) begin
      eq   = (1 << DW) - 1;
      er   = dd % (1 << VW);
      edz  = FAST ? 1 : 0;
      elat = FAST ? 1 : DW;
    end else begin
      eq   = dd / dv;
      er   = dd % dv;
      edz  = 0;
      elat = DW;
    end
    @(negedge clk);
    chk("ready_idle", in_ready, 1);
    dividend = DW'(dd);
    divisor  = VW'(dv);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
    chk("busy_ready", in_ready, 0);
    chk("calc_quot0", quotient, 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 40);
    chk("latency", lat, elat);
    chk("quot", quotient, eq);
    chk("rem", remainder, er);
    chk("dz", div_by_zero, edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      dividend = DW'($urandom);
      divisor  = VW'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_ready", in_ready, 0);
      chk("hold_quot", quotient, eq);
      chk("hold_rem", remainder, er);
      chk("hold_dz", div_by_zero, edz);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_quot", quotient, 0);
  endtask

  initial begin
    int seen;
    #12;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_dz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(200, 7, 0);
    do_op(255, 15, 0);
    do_op(0, 9, 0);
    do_op(255, 1, 0);
    do_op(5, 0, 0);
    do_op(77, 5, 5);

    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 1);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    chk("abort_dz", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort_no_out", seen, 0);
    do_op(100, 3, 0);

    for (int k = 0; k < 40; k++) begin
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=1 exp=0");
    $fatal(1);
  end

endmodule

// File: doc/seq_restoring_divider.md
SEQ_RESTORING_DIVIDER -- requirements
Module: seq_restoring_divider

Interface
REQ-001 SHALL have parameter DW, default 8, dividend and quotient width in bits.
REQ-002 SHALL have parameter VW, default 4, divisor and remainder width in bits; VW < DW.
REQ-003 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operands valid.
REQ-006 SHALL have port in_ready, output, 1, block can accept operands.
REQ-007 SHALL have port dividend, input, DW, unsigned dividend.
REQ-008 SHALL have port divisor, input, VW, unsigned divisor.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port quotient, output, DW, unsigned quotient.
REQ-012 SHALL have port remainder, output, VW, unsigned remainder.
REQ-013 SHALL have port div_by_zero, output, 1, result came from a zero divisor.

Function
REQ-014 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-015 SHALL drive in_ready high only in IDLE, combinationally from state.
REQ-016 SHALL accept operands on a rising edge where in_valid && in_ready; on that edge it SHALL register dividend and divisor, clear the partial remainder (VW+1 bits), and enter CALC.
REQ-017 SHALL ignore dividend and divisor changes after acceptance.
REQ-018 SHALL, in CALC, perform one restoring step per cycle, MSB first:
  - shift the next dividend bit into the partial remainder;
  - trial-subtract the divisor;
  - keep the difference and set the quotient bit to 1 if the difference is non-negative, else restore and set the quotient bit to 0.
REQ-019 SHALL complete exactly DW steps; out_valid SHALL rise on the DW-th edge after the accept edge (8 for the defaults), with the FSM entering DONE.
REQ-020 SHALL hold quotient, remainder, div_by_zero and out_valid stable in DONE until out_valid && out_ready on an edge, then return to IDLE; in_ready SHALL rise the following cycle, with no same-cycle re-accept.
REQ-021 SHALL, for a zero divisor, produce quotient = all ones and remainder = dividend[VW-1:0].
REQ-022 SHALL, when the true remainder fits in VW bits, satisfy dividend = quotient*divisor + remainder for every nonzero divisor; quotient overflow cannot occur since the quotient is DW bits.
REQ-023 SHALL drive quotient and remainder to 0 outside DONE.

Reset
REQ-024 SHALL, while rst_n is low, force state IDLE and out_valid, quotient, remainder, div_by_zero and all internal registers to 0; in_ready SHALL be 1.
REQ-025 SHALL abort any in-flight CALC or DONE operation on reset assertion and discard it, with no out_valid produced.

Configuration
REQ-026 SHALL support macro DIVZ_FAST_EN.
  - Defined: a zero divisor is detected at accept, DONE is entered on the next edge (latency 1), and div_by_zero = 1.
  - Undefined: a zero divisor runs the full DW steps with the REQ-021 result, and div_by_zero is tied to 0.

Structure
REQ-027 SHALL place default DW/VW constants and the state enum (IDLE, CALC, DONE) in shared package div_pkg.
REQ-028 SHALL instantiate sub-module sub_cell, a combinational (VW+1)-bit trial subtract with restore mux, producing the next partial remainder and the quotient bit.

Verification
REQ-029 SHALL cover: 200/7 -> quotient 28, remainder 4, out_valid 8 cycles after accept.
REQ-030 SHALL cover: 255/15 -> quotient 17, remainder 0; 0/9 -> quotient 0, remainder 0; 255/1 -> quotient 255, remainder 0.
REQ-031 SHALL cover: 5/0 -> quotient 255, remainder 5; with DIVZ_FAST_EN, div_by_zero 1 and latency 1; without it, div_by_zero 0 and latency 8.
REQ-032 SHALL cover: out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0, in_valid ignored; release -> IDLE, in_ready 1 next cycle.
REQ-033 SHALL cover: rst_n pulsed low on step 4 of CALC -> outputs 0 immediately, no out_valid; the next op 100/3 -> quotient 33, remainder 1.
